// File: rtl/instr_loader.sv
// UART boot loader: parses A5 | count_hi | count_lo | words | xor and writes
// big-endian instruction words into RAM while holding the CPU in reset.
module instr_loader #(
    parameter int TIMEOUT = 1000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        we,
    output logic [9:0]  waddr,
    output logic [31:0] wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        CNT_HI,
        CNT_LO,
        DATA,
        CSUM
    } state_t;

    localparam logic [31:0] TLIM = 32'(TIMEOUT - 1);

    state_t      state;
    logic [7:0]  cnt_hi;
    logic [7:0]  acc;
    logic [23:0] word;
    logic [1:0]  lane;
    logic [9:0]  idx;
    logic [9:0]  last_idx;
    logic [31:0] tcnt;

    logic [15:0] cnt_full;
    logic [9:0]  cnt_low;
    logic        cnt_bad;

    assign cnt_full = {cnt_hi, rx_data};
    assign cnt_low  = {cnt_hi[1:0], rx_data};
    assign cnt_bad  = (cnt_full == 16'd0) || (cnt_full > 16'd1024);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            we       <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            cpu_hold <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            cnt_hi   <= '0;
            acc      <= '0;
            word     <= '0;
            lane     <= '0;
            idx      <= '0;
            last_idx <= '0;
            tcnt     <= '0;
        end else begin
            we <= 1'b0;
            if (rx_valid) begin
                // A byte always wins over a timeout expiring in the same cycle.
                tcnt <= '0;
                unique case (state)
                    IDLE: begin
                        if (rx_data == 8'hA5) begin
                            state    <= CNT_HI;
                            cpu_hold <= 1'b1;
                            done     <= 1'b0;
                            err      <= 1'b0;
                            acc      <= '0;
                            idx      <= '0;
                            lane     <= '0;
                        end
                    end
                    CNT_HI: begin
                        cnt_hi <= rx_data;
                        state  <= CNT_LO;
                    end
                    CNT_LO: begin
                        if (cnt_bad) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            last_idx <= cnt_low - 10'd1;
                            state    <= DATA;
                        end
                    end
                    DATA: begin
                        acc  <= acc ^ rx_data;
                        lane <= lane + 2'd1;
                        word <= {word[15:0], rx_data};
                        if (lane == 2'd3) begin
                            we    <= 1'b1;
                            waddr <= idx;
                            wdata <= {word, rx_data};
                            idx   <= idx + 10'd1;
                            // Move on now so a byte in the we cycle is the checksum.
                            if (idx == last_idx) begin
                                state <= CSUM;
                            end
                        end
                    end
                    CSUM: begin
                        if (rx_data == acc) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (tcnt == TLIM) begin
                    err   <= 1'b1;
                    state <= IDLE;
                    tcnt  <= '0;
                end else begin
                    tcnt <= tcnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Bench for instr_loader: directed vectors plus random packets checked
// against a packet-level model of the load protocol.
module tb_instr_loader;

    localparam int TO = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        we;
    logic [9:0]  waddr;
    logic [31:0] wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [9:0]  wa_q[$];
    logic [31:0] wd_q[$];
    logic [7:0]  pkt[$];
    logic [31:0] exp_w[$];
    logic        exp_done;
    logic        exp_err;

    instr_loader #(.TIMEOUT(TO)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .we(we),
        .waddr(waddr),
        .wdata(wdata),
        .cpu_hold(cpu_hold),
        .busy(busy),
        .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && we) begin
            wa_q.push_back(waddr);
            wd_q.push_back(wdata);
        end
    end

    task automatic send(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input int gap);
        foreach (pkt[i]) begin
            if (gap > 0) idle($urandom_range(0, gap));
            send(pkt[i]);
        end
    endtask

    // Whole-packet view: count, word list, xor of payload, verdict.
    task automatic ref_model();
        int cnt;
        logic [7:0] x;
        exp_w.delete();
        cnt = int'({pkt[1], pkt[2]});
        if (cnt == 0 || cnt > 1024) begin
            exp_err  = 1'b1;
            exp_done = 1'b0;
            return;
        end
        x = 8'h00;
        for (int i = 0; i < cnt; i++)
            exp_w.push_back({pkt[3+4*i], pkt[4+4*i], pkt[5+4*i], pkt[6+4*i]});
        for (int j = 0; j < 4 * cnt; j++)
            x = x ^ pkt[3+j];
        exp_done = (pkt[3+4*cnt] == x);
        exp_err  = !exp_done;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({we, waddr, wdata, cpu_hold, busy, done, err} !== 48'd0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b waddr=%h wdata=%h hold=%b busy=%b done=%b err=%b, want all 0",
                     we, waddr, wdata, cpu_hold, busy, done, err);
        end
        idle(3);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic();
        wa_q.delete(); wd_q.delete();
        pkt = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44,
                8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h66};
        send_pkt(0);
        idle(2);
        checks++;
        if (wa_q.size() !== 2) begin
            errors++;
            $display("FAIL basic_nwrites: got %0d want 2", wa_q.size());
        end else begin
            checks++;
            if (wa_q[0] !== 10'd0 || wd_q[0] !== 32'h11223344) begin
                errors++;
                $display("FAIL basic_w0: got %h:%h want 000:11223344", wa_q[0], wd_q[0]);
            end
            checks++;
            if (wa_q[1] !== 10'd1 || wd_q[1] !== 32'hDEADBEEF) begin
                errors++;
                $display("FAIL basic_w1: got %h:%h want 001:deadbeef", wa_q[1], wd_q[1]);
            end
        end
        checks++;
        if ({done, err, cpu_hold, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL basic_flags: got done/err/hold/busy=%b%b%b%b want 1000",
                     done, err, cpu_hold, busy);
        end
    endtask

    task automatic test_bad_csum();
        wa_q.delete(); wd_q.delete();
        pkt = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF};
        send_pkt(0);
        idle(2);
        checks++;
        if (wa_q.size() !== 1 || wa_q[0] !== 10'd0 || wd_q[0] !== 32'h01020304) begin
            errors++;
            $display("FAIL badcsum_write: got %0d writes first %h want 1 write 01020304",
                     wa_q.size(), wa_q.size() > 0 ? wd_q[0] : 32'h0);
        end
        checks++;
        if ({done, err, cpu_hold, busy} !== 4'b0110) begin
            errors++;
            $display("FAIL badcsum_flags: got done/err/hold/busy=%b%b%b%b want 0110",
                     done, err, cpu_hold, busy);
        end
    endtask

    task automatic test_bad_count();
        wa_q.delete(); wd_q.delete();
        pkt = '{8'hA5, 8'h04, 8'h01};
        send_pkt(0);
        idle(2);
        checks++;
        if ({done, err, cpu_hold, busy} !== 4'b0110 || wa_q.size() !== 0) begin
            errors++;
            $display("FAIL count1025: got done/err/hold/busy=%b%b%b%b writes=%0d want 0110 0",
                     done, err, cpu_hold, busy, wa_q.size());
        end
        send(8'h00);
        idle(2);
        checks++;
        if (busy !== 1'b0 || err !== 1'b1) begin
            errors++;
            $display("FAIL count_idle_ignore: got busy=%b err=%b want 0 1", busy, err);
        end
        pkt = '{8'hA5, 8'h00, 8'h00};
        send_pkt(0);
        idle(2);
        checks++;
        if ({err, busy} !== 2'b10 || wa_q.size() !== 0) begin
            errors++;
            $display("FAIL count0: got err=%b busy=%b writes=%0d want 1 0 0",
                     err, busy, wa_q.size());
        end
    endtask

    task automatic test_timeout();
        logic [7:0] d[4];
        wa_q.delete(); wd_q.delete();
        pkt = '{8'hA5, 8'h00, 8'h01, 8'hAA};
        send_pkt(0);
        idle(TO - 1);
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_early: got busy=%b err=%b want 1 0", busy, err);
        end
        idle(1);
        checks++;
        if ({err, busy, cpu_hold} !== 3'b101 || wa_q.size() !== 0) begin
            errors++;
            $display("FAIL timeout_abort: got err/busy/hold=%b%b%b writes=%0d want 101 0",
                     err, busy, cpu_hold, wa_q.size());
        end
        d = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        send(8'hA5);
        send(8'h00);
        send(8'h01);
        for (int i = 0; i < 4; i++) begin
            idle(TO - 1);
            send(d[i]);
        end
        idle(TO - 1);
        send(8'h00);
        idle(2);
        checks++;
        if ({done, err, cpu_hold} !== 3'b100 || wa_q.size() !== 1 || wd_q[0] !== 32'hAABBCCDD) begin
            errors++;
            $display("FAIL timeout_edge: got done/err/hold=%b%b%b writes=%0d want 100 1",
                     done, err, cpu_hold, wa_q.size());
        end
    endtask

    task automatic test_ignore_and_reset();
        send(8'h37);
        idle(2);
        checks++;
        if ({busy, done, cpu_hold} !== 3'b010) begin
            errors++;
            $display("FAIL idle_ignore: got busy/done/hold=%b%b%b want 010", busy, done, cpu_hold);
        end
        pkt = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34};
        send_pkt(0);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({we, waddr, wdata, cpu_hold, busy, done, err} !== 48'd0) begin
            errors++;
            $display("FAIL async_reset: got wdata=%h hold=%b busy=%b done=%b err=%b want 0",
                     wdata, cpu_hold, busy, done, err);
        end
        idle(2);
        rst_n = 1'b1;
        wa_q.delete(); wd_q.delete();
        send(8'h12);
        idle(2);
        checks++;
        if (busy !== 1'b0 || wa_q.size() !== 0) begin
            errors++;
            $display("FAIL post_reset_idle: got busy=%b writes=%0d want 0 0", busy, wa_q.size());
        end
    endtask

    task automatic test_random();
        int cnt;
        logic [7:0] b;
        logic [7:0] x;
        for (int n = 0; n < 30; n++) begin
            wa_q.delete(); wd_q.delete();
            pkt.delete();
            for (int g = $urandom_range(0, 3); g > 0; g--) begin
                b = 8'($urandom);
                if (b == 8'hA5) b = 8'h5A;
                pkt.push_back(b);
            end
            send_pkt(2);
            pkt.delete();
            pkt.push_back(8'hA5);
            if ($urandom_range(0, 7) == 0) begin
                cnt = ($urandom_range(0, 1) == 0) ? 0 : 1025 + $urandom_range(0, 3000);
                pkt.push_back(8'(cnt >> 8));
                pkt.push_back(8'(cnt));
            end else begin
                cnt = $urandom_range(1, 6);
                pkt.push_back(8'(cnt >> 8));
                pkt.push_back(8'(cnt));
                x = 8'h00;
                for (int j = 0; j < 4 * cnt; j++) begin
                    b = ($urandom_range(0, 5) == 0) ? 8'hA5 : 8'($urandom);
                    x = x ^ b;
                    pkt.push_back(b);
                end
                if ($urandom_range(0, 3) == 0) x = x ^ 8'(1 << $urandom_range(0, 7));
                pkt.push_back(x);
            end
            send_pkt(($urandom_range(0, 3) == 0) ? TO - 1 : 2);
            idle(2);
            ref_model();
            checks++;
            if (wa_q.size() !== exp_w.size()) begin
                errors++;
                $display("FAIL rand%0d_nwrites: got %0d want %0d", n, wa_q.size(), exp_w.size());
            end else begin
                foreach (exp_w[i]) begin
                    checks++;
                    if (wa_q[i] !== 10'(i) || wd_q[i] !== exp_w[i]) begin
                        errors++;
                        $display("FAIL rand%0d_w%0d: got %h:%h want %h:%h",
                                 n, i, wa_q[i], wd_q[i], 10'(i), exp_w[i]);
                    end
                end
            end
            checks++;
            if ({done, err, cpu_hold, busy} !== {exp_done, exp_err, exp_err, 1'b0}) begin
                errors++;
                $display("FAIL rand%0d_flags: got done/err/hold/busy=%b%b%b%b want %b%b%b0",
                         n, done, err, cpu_hold, busy, exp_done, exp_err, exp_err);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] b;
        logic [7:0] x;
        int bad;
        wa_q.delete(); wd_q.delete();
        pkt = '{8'hA5, 8'h04, 8'h00};
        x = 8'h00;
        for (int j = 0; j < 4096; j++) begin
            b = 8'($urandom);
            x = x ^ b;
            pkt.push_back(b);
        end
        pkt.push_back(x);
        send_pkt(0);
        idle(2);
        ref_model();
        checks++;
        if (wa_q.size() !== 1024 || exp_w.size() !== 1024) begin
            errors++;
            $display("FAIL b2b_nwrites: got %0d want 1024", wa_q.size());
        end else begin
            bad = 0;
            foreach (exp_w[i])
                if (wa_q[i] !== 10'(i) || wd_q[i] !== exp_w[i]) bad++;
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL b2b_words: got %0d wrong words want 0", bad);
            end
        end
        checks++;
        if ({done, err, cpu_hold, busy} !== 4'b1000) begin
            errors++;
            $display("FAIL b2b_flags: got done/err/hold/busy=%b%b%b%b want 1000",
                     done, err, cpu_hold, busy);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bad_csum();
        test_bad_count();
        test_timeout();
        test_ignore_and_reset();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
